// File: rtl/decoder_pkg.sv
// Shared FSM state type and mode encodings for scan_decoder and its decoder.
package decoder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_t;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/onehot_decoder.sv
// Combinational one-hot decode of a select value; all-zero when not enabled.
module onehot_decoder
  import decoder_pkg::*;
#(
  parameter int SEL_W = 3
) (
  input  logic [SEL_W-1:0]        S,
  input  logic                    enable,
  output logic [(2**SEL_W)-1:0]   out
);

  // Set exactly the selected bit when enabled.
  always_comb begin
    out = {(2**SEL_W){1'b0}};
    if (enable) begin
      out[S] = 1'b1;
    end else begin
      out = {(2**SEL_W){1'b0}};
    end
  end

endmodule

// File: rtl/scan_decoder.sv
// Registered one-hot decoder with direct-select and timed auto-scan modes.
// Build option: SCAN_DECODER_ACTIVE_LOW_EN drives out inverted (idle/reset all ones).
module scan_decoder
  import decoder_pkg::*;
#(
  parameter int SEL_W = 3,
  parameter int DWELL = 4,
  parameter int WRAP  = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   mode,
  input  logic                   sel_valid,
  output logic                   sel_ready,
  input  logic [SEL_W-1:0]       S,
  output logic [(2**SEL_W)-1:0]  out,
  output logic [SEL_W-1:0]       index,
  output logic                   busy,
  output logic                   done
);

  localparam int N_OUT = 2**SEL_W;
  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic [SEL_W-1:0] IDX_LAST   = SEL_W'(N_OUT - 1);
`ifdef SCAN_DECODER_ACTIVE_LOW_EN
  localparam logic [N_OUT-1:0] OUT_POL = {N_OUT{1'b1}};
`else
  localparam logic [N_OUT-1:0] OUT_POL = {N_OUT{1'b0}};
`endif

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   index_q, index_d;
  logic [CNT_W-1:0]   dwell_q, dwell_d;
  logic [N_OUT-1:0]   out_q, out_d;
  logic               busy_q;
  logic               done_q, done_d;
  logic               hs_s;
  logic               active_s;
  logic [N_OUT-1:0]   dec_s;

  assign sel_ready = (state_q != SCAN);
  assign hs_s      = sel_valid && sel_ready && enable;
  assign active_s  = (state_d != IDLE);

  // Decode the next index so out lands in the same cycle as the new state.
  onehot_decoder #(.SEL_W(SEL_W)) u_dec (
    .S      (index_d),
    .enable (active_s),
    .out    (dec_s)
  );

  // Next-state, index and dwell sequencing.
  always_comb begin
    state_d = state_q;
    index_d = index_q;
    dwell_d = dwell_q;
    done_d  = 1'b0;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DIRECT: begin
          if (hs_s) begin
            index_d = S;
            dwell_d = {CNT_W{1'b0}};
            state_d = (mode == MODE_SCAN) ? SCAN : DIRECT;
          end else begin
            state_d = state_q;
          end
        end
        SCAN: begin
          if (dwell_q == DWELL_LAST) begin
            dwell_d = {CNT_W{1'b0}};
            if (index_q == IDX_LAST) begin
              if (WRAP != 0) begin
                index_d = {SEL_W{1'b0}};
              end else begin
                state_d = IDLE;
                done_d  = 1'b1;
              end
            end else begin
              index_d = index_q + {{(SEL_W-1){1'b0}}, 1'b1};
            end
          end else begin
            dwell_d = dwell_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
    out_d = dec_s ^ OUT_POL;
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      index_q <= {SEL_W{1'b0}};
      dwell_q <= {CNT_W{1'b0}};
      out_q   <= OUT_POL;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      dwell_q <= dwell_d;
      out_q   <= out_d;
      busy_q  <= (state_d == SCAN);
      done_q  <= done_d;
    end
  end

  assign out   = out_q;
  assign index = index_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: doc/scan_decoder.md
SCAN_DECODER -- requirements
Module: scan_decoder

Interface
REQ-001 SHALL have parameter SEL_W, default 3: select width; N_OUT = 2**SEL_W outputs.
REQ-002 SHALL have parameter DWELL, default 4: cycles each output is held in scan mode; legal range 1..65535.
REQ-003 SHALL have parameter WRAP, default 1: 1 = scan wraps forever, 0 = single sweep then stop.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 enable  input  1  block enable; low forces outputs inactive.
REQ-007 mode  input  1  0 = direct decode, 1 = auto-scan; sampled only on handshake.
REQ-008 sel_valid  input  1  S/mode valid request.
REQ-009 sel_ready  output  1  block accepts a request this cycle.
REQ-010 S  input  SEL_W  select (direct) or start index (scan).
REQ-011 out  output  N_OUT  registered one-hot decode of index.
REQ-012 index  output  SEL_W  currently decoded index.
REQ-013 busy  output  1  high while in SCAN.
REQ-014 done  output  1  one-cycle pulse at end of a non-wrapping sweep.

Function
REQ-015 SHALL implement FSM states IDLE, DIRECT, SCAN.
REQ-016 Handshake SHALL occur when sel_valid && sel_ready && enable; sel_ready = 1 in IDLE and DIRECT, 0 in SCAN.
REQ-017 Handshake with mode=0 SHALL load index <= S, go DIRECT; out = one-hot(S) on the following cycle (1-cycle latency).
REQ-018 In DIRECT a further handshake with mode=0 SHALL update index/out with the same 1-cycle latency; mode=1 SHALL enter SCAN from index S.
REQ-019 Handshake in IDLE with mode=1 SHALL load index <= S, clear dwell counter, go SCAN.
REQ-020 In SCAN the dwell counter SHALL count 0..DWELL-1; on DWELL-1 it clears and index increments by 1.
REQ-021 At index = N_OUT-1 and dwell end: WRAP=1 -> index <= 0, stay SCAN; WRAP=0 -> go IDLE, index held, out <= 0, done = 1 for exactly one cycle.
REQ-022 DWELL=1 SHALL advance index every cycle.
REQ-023 enable low in any state SHALL, next cycle, force out <= 0, state <= IDLE, no done pulse; index retained.
REQ-024 out SHALL be all-zero in IDLE and exactly one bit set in DIRECT/SCAN.
REQ-025 busy SHALL equal (state == SCAN), registered.
REQ-026 sel_valid while sel_ready=0 SHALL be ignored with no state change.

Reset
REQ-027 reset high SHALL asynchronously force state IDLE, out 0, index 0, dwell counter 0, busy 0, done 0; sel_ready is 1 from the first cycle after release.
REQ-028 reset asserted mid-scan SHALL abort with no done pulse.

Configuration
REQ-029 Macro SCAN_DECODER_ACTIVE_LOW_EN defined: out SHALL be driven bit-inverted (active-low, board LED/HEX style), reset value all ones, idle value all ones; undefined: active-high as above. Only out is affected.

Structure
REQ-030 Package decoder_pkg SHALL hold the FSM state typedef (state_t: IDLE, DIRECT, SCAN) and the mode constants MODE_DIRECT=0, MODE_SCAN=1.
REQ-031 Sub-module onehot_decoder (parameter SEL_W; ports S, enable, out) SHALL provide the combinational one-hot decode, registered in scan_decoder.

Verification
REQ-032 SEL_W=3: reset, enable=1, handshake mode=0 S=5 -> next cycle out=8'b0010_0000, index=5, busy=0.
REQ-033 SEL_W=3 DWELL=2 WRAP=1: handshake mode=1 S=6 -> out bit6 for 2 cycles, bit7 for 2, then bit0; sel_ready=0, busy=1 throughout.
REQ-034 SEL_W=2 DWELL=1 WRAP=0: handshake mode=1 S=0 -> out 0001,0010,0100,1000 on successive cycles, then out=0, done=1 one cycle, state IDLE.
REQ-035 Mid-scan enable=0 -> next cycle out=0, busy=0, done stays 0; sel_valid during scan ignored.
REQ-036 Reset asserted asynchronously mid-scan (between edges) -> out=0, index=0 immediately; with SCAN_DECODER_ACTIVE_LOW_EN, out=8'hFF in reset and idle.
